uart_rx_dma_ctrl: RTL

//  Drains the UART receive FIFO autonomously and presents packed received bytes to a
//  bus-master/DMA engine through a req/ack handshake. Starts a drain burst on the FIFO

---
 rtl/uart_rx_dma_ctrl_pkg.sv | 30 +++
 rtl/uart_rx_dma_ctrl_if.sv | 12 +
 rtl/uart_rx_pack.sv | 47 ++++
 rtl/uart_rx_dma_ctrl.sv | 91 +++++++++
 4 files changed

// File: rtl/uart_rx_dma_ctrl_pkg.sv
// rtl/uart_rx_dma_ctrl_pkg.sv - shared types, FIFO record layout and trigger decode for the UART RX DMA drain
package uart_rx_dma_ctrl_pkg;

  localparam int FIFO_COUNTER_W = 5;
  localparam int FIFO_REC_WIDTH = 11;
  localparam int REC_DATA_LSB   = 3;
  localparam int ERR_W          = 3;

  // Error bit positions inside the FIFO record and err_stat
  localparam int ERR_BREAK   = 2;
  localparam int ERR_PARITY  = 1;
  localparam int ERR_FRAMING = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_SETTLE,
    ST_REQ
  } state_e;

  function automatic logic [FIFO_COUNTER_W-1:0] trig_level(input logic [1:0] sel);
    case (sel)
      2'b00:   trig_level = FIFO_COUNTER_W'(1);
      2'b01:   trig_level = FIFO_COUNTER_W'(4);
      2'b10:   trig_level = FIFO_COUNTER_W'(8);
      default: trig_level = FIFO_COUNTER_W'(14);
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_dma_ctrl_if.sv
// rtl/uart_rx_dma_ctrl_if.sv - req/ack word handshake between the RX drain and the DMA engine
interface uart_rx_dma_ctrl_if #(
  parameter int BYTES_PER_WORD = 4
);
  logic                          dma_req;
  logic [8*BYTES_PER_WORD-1:0]   dma_data;
  logic [2:0]                    dma_bytes;
  logic                          dma_ack;

  modport master (output dma_req, output dma_data, output dma_bytes, input dma_ack);
  modport slave  (input dma_req, input dma_data, input dma_bytes, output dma_ack);
endinterface

// File: rtl/uart_rx_pack.sv
// rtl/uart_rx_pack.sv - byte-lane packer: writes bytes lane by lane, counts them, clears on ack
module uart_rx_pack #(
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_byte,
  input  logic                        clr,
  output logic [8*BYTES_PER_WORD-1:0] data,
  output logic [2:0]                  count,
  output logic                        full
);

  logic [8*BYTES_PER_WORD-1:0] data_q, data_d;
  logic [2:0]                  idx_q, idx_d;

  assign full  = (idx_q == 3'(BYTES_PER_WORD));
  assign data  = data_q;
  assign count = idx_q;

  // Clearing leaves unused lanes at zero for the next word
  always_comb begin
    data_d = data_q;
    idx_d  = idx_q;
    if (clr) begin
      data_d = '0;
      idx_d  = '0;
    end else if (wr_en && !full) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (idx_q == 3'(i)) data_d[8*i +: 8] = wr_byte;
      end
      idx_d = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      idx_q  <= '0;
    end else begin
      data_q <= data_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/uart_rx_dma_ctrl.sv
// rtl/uart_rx_dma_ctrl.sv - drains the UART RX FIFO into packed DMA words with sticky error status
module uart_rx_dma_ctrl
  import uart_rx_dma_ctrl_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                      clk,
  input  logic                      wb_rst_i,
  input  logic                      dma_en,
  input  logic [1:0]                trig_lvl,
  input  logic [FIFO_COUNTER_W-1:0] rf_count,
  input  logic [FIFO_REC_WIDTH-1:0] rf_data_out,
  input  logic [9:0]                counter_t,
  output logic                      rf_pop,
  output logic [ERR_W-1:0]          err_stat,
  output logic                      err_irq,
  input  logic                      err_clr,
  uart_rx_dma_ctrl_if.master        dma
);

  state_e             state_q, state_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               trig;
  logic               fifo_empty;
  logic               pack_wr, pack_clr, pack_full;
  logic [2:0]         pack_count;

  assign fifo_empty = (rf_count == '0);
  assign trig = dma_en && !fifo_empty &&
                ((rf_count >= trig_level(trig_lvl)) || (counter_t == 10'd0));

  uart_rx_pack #(.BYTES_PER_WORD(BYTES_PER_WORD)) u_pack (
    .clk     (clk),
    .rst     (wb_rst_i),
    .wr_en   (pack_wr),
    .wr_byte (rf_data_out[REC_DATA_LSB +: 8]),
    .clr     (pack_clr),
    .data    (dma.dma_data),
    .count   (pack_count),
    .full    (pack_full)
  );

  assign dma.dma_bytes = pack_count;
  assign dma.dma_req   = (state_q == ST_REQ);
  assign err_stat      = err_q;
  assign err_irq       = |err_q;

  always_comb begin
    state_d  = state_q;
    rf_pop   = 1'b0;
    pack_wr  = 1'b0;
    pack_clr = 1'b0;
    err_d    = err_clr ? '0 : err_q;
    case (state_q)
      ST_IDLE: if (trig) state_d = ST_POP;
      // A same-cycle dma_en drop aborts the pop so a disabled block never pops
      ST_POP: begin
        if (!dma_en) begin
          state_d = (pack_count == 3'd0) ? ST_IDLE : ST_REQ;
        end else begin
          rf_pop  = 1'b1;
          pack_wr = 1'b1;
          err_d   = err_d | rf_data_out[ERR_W-1:0];
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (pack_full || fifo_empty || !dma_en) state_d = ST_REQ;
        else                                    state_d = ST_POP;
      end
      ST_REQ: begin
        if (dma.dma_ack) begin
          pack_clr = 1'b1;
          state_d  = (dma_en && !fifo_empty) ? ST_POP : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

endmodule
